// File: rtl/core_pkg.sv
// Shared core definitions for the register-file write path.
//   XLEN        : datapath width of results and write-port data
//   NREG        : architectural register count
//   reg_addr_t  : register address (5 bits, x0..x31)
//   word_t      : one XLEN-wide data word
//   src_e       : identifies a result source for the write-port arbiter
package core_pkg;
  localparam int XLEN = 32;
  localparam int NREG = 32;

  typedef logic [4:0]      reg_addr_t;
  typedef logic [XLEN-1:0] word_t;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_MEM = 1'b1
  } src_e;
endpackage

// File: rtl/regfile_writer_scoreboard.sv
// Register busy-bit scoreboard.
// Tracks which architectural registers have a result still in flight.
//   clk, rst_n      : clock / async active-low reset (clears all busy bits)
//   set_en, set_rd  : mark set_rd busy on the next edge (issue accepted)
//   clr_en, clr_rd  : mark clr_rd free on the next edge (result retired)
//   rs1, rs2, rd    : operands of the instruction trying to issue
//   hazard          : any of rs1/rs2/rd currently busy
module scoreboard
  import core_pkg::*;
#(
  parameter int NREG = core_pkg::NREG
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      set_en,
  input  reg_addr_t set_rd,
  input  logic      clr_en,
  input  reg_addr_t clr_rd,
  input  reg_addr_t rs1,
  input  reg_addr_t rs2,
  input  reg_addr_t rd,
  output logic      hazard
);

  logic [NREG-1:0] busy_q, busy_d;

  // Clear first, then set: when an issue and a retire target the same
  // register on one edge the new producer owns it, so the set must win.
  // Clearing a bit that is already 0 (stray retire) leaves state as-is.
  always_comb begin
    busy_d = busy_q;
    if (clr_en) busy_d[clr_rd] = 1'b0;
    if (set_en) busy_d[set_rd] = 1'b1;
    busy_d[0] = 1'b0;  // x0 is never a real destination
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  assign hazard = busy_q[rs1] | busy_q[rs2] | busy_q[rd];

endmodule

// File: rtl/regfile_writer.sv
// Register-file writer: issue hazard check plus write-port arbitration.
// Decode asks to issue; the scoreboard stalls it while any operand or the
// destination has a result outstanding. ALU and load results compete for
// the single register-file write port (we3/a3/wd3) through a round-robin
// arbiter; the winner is registered and written one cycle later.
//   clk, rst_n                  : clock / async active-low reset
//   iss_valid/rd/rs1/rs2        : issue request from decode
//   iss_stall                   : issue blocked by a hazard this cycle
//   alu_valid/rd/data, alu_ready: ALU result handshake
//   mem_valid/rd/data, mem_ready: load result handshake
//   we3, a3, wd3                : register-file write port
module regfile_writer
  import core_pkg::*;
#(
  parameter int XLEN = core_pkg::XLEN,
  parameter int NREG = core_pkg::NREG
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            iss_valid,
  input  reg_addr_t       iss_rd,
  input  reg_addr_t       iss_rs1,
  input  reg_addr_t       iss_rs2,
  output logic            iss_stall,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  reg_addr_t       alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            mem_valid,
  output logic            mem_ready,
  input  reg_addr_t       mem_rd,
  input  logic [XLEN-1:0] mem_data,
  output logic            we3,
  output reg_addr_t       a3,
  output logic [XLEN-1:0] wd3
);

  // ---------------------------------------------------------------------
  // Issue side
  // ---------------------------------------------------------------------
  logic hazard;
  logic iss_accept;

  // Gated by rst_n so the stall output is quiet while reset is held.
  assign iss_stall  = rst_n & iss_valid & hazard;
  assign iss_accept = rst_n & iss_valid & ~hazard;

  // ---------------------------------------------------------------------
  // Round-robin arbiter
  // last_q remembers who won the most recent grant; on a conflict the
  // other source wins. Resetting to SRC_ALU makes mem win first.
  // Grants look only at valids and last_q, never at rd/data.
  // ---------------------------------------------------------------------
  src_e last_q, last_d;
  logic grant_alu, grant_mem, grant_any;

  always_comb begin
    grant_alu = 1'b0;
    grant_mem = 1'b0;
    if (rst_n) begin
      if (alu_valid && mem_valid) begin
        grant_mem = (last_q == SRC_ALU);
        grant_alu = (last_q == SRC_MEM);
      end else begin
        grant_alu = alu_valid;
        grant_mem = mem_valid;
      end
    end
  end

  assign grant_any = grant_alu | grant_mem;
  assign alu_ready = grant_alu;
  assign mem_ready = grant_mem;

  always_comb begin
    last_d = last_q;
    if (grant_mem)      last_d = SRC_MEM;
    else if (grant_alu) last_d = SRC_ALU;
  end

  // ---------------------------------------------------------------------
  // Winning result and write-port registers
  // ---------------------------------------------------------------------
  reg_addr_t       win_rd;
  logic [XLEN-1:0] win_data;
  logic            win_wr;

  assign win_rd   = grant_mem ? mem_rd   : alu_rd;
  assign win_data = grant_mem ? mem_data : alu_data;
  // A result aimed at x0 still completes its handshake but never writes.
  assign win_wr   = grant_any & (win_rd != '0);

  logic            we3_q, we3_d;
  reg_addr_t       a3_q,  a3_d;
  logic [XLEN-1:0] wd3_q, wd3_d;

  // we3 is a one-cycle pulse; a3/wd3 keep the last accepted result
  // when nothing is granted.
  always_comb begin
    we3_d = win_wr;
    a3_d  = a3_q;
    wd3_d = wd3_q;
    if (grant_any) begin
      a3_d  = win_rd;
      wd3_d = win_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we3_q  <= 1'b0;
      a3_q   <= '0;
      wd3_q  <= '0;
      last_q <= SRC_ALU;
    end else begin
      we3_q  <= we3_d;
      a3_q   <= a3_d;
      wd3_q  <= wd3_d;
      last_q <= last_d;
    end
  end

  assign we3 = we3_q;
  assign a3  = a3_q;
  assign wd3 = wd3_q;

  // ---------------------------------------------------------------------
  // Scoreboard: set on accepted issue, clear on the same edge that
  // registers the write.
  // ---------------------------------------------------------------------
  scoreboard #(
    .NREG (NREG)
  ) u_sb (
    .clk    (clk),
    .rst_n  (rst_n),
    .set_en (iss_accept),
    .set_rd (iss_rd),
    .clr_en (win_wr),
    .clr_rd (win_rd),
    .rs1    (iss_rs1),
    .rs2    (iss_rs2),
    .rd     (iss_rd),
    .hazard (hazard)
  );

endmodule

// File: tb/tb_regfile_writer.sv
module tb_regfile_writer;
  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            iss_valid;
  logic [4:0]      iss_rd, iss_rs1, iss_rs2;
  logic            iss_stall;
  logic            alu_valid, alu_ready;
  logic [4:0]      alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            mem_valid, mem_ready;
  logic [4:0]      mem_rd;
  logic [XLEN-1:0] mem_data;
  logic            we3;
  logic [4:0]      a3;
  logic [XLEN-1:0] wd3;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  regfile_writer #(.XLEN(XLEN), .NREG(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .iss_rs1   (iss_rs1),
    .iss_rs2   (iss_rs2),
    .iss_stall (iss_stall),
    .alu_valid (alu_valid),
    .alu_ready (alu_ready),
    .alu_rd    (alu_rd),
    .alu_data  (alu_data),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_rd    (mem_rd),
    .mem_data  (mem_data),
    .we3       (we3),
    .a3        (a3),
    .wd3       (wd3)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock edge, then step 1 time unit past it.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic v, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2);
    iss_valid = v;
    iss_rd    = rd;
    iss_rs1   = rs1;
    iss_rs2   = rs2;
  endtask

  // Invariants sampled on the falling edge.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      chk("inv_we3_x0", {63'd0, (we3 === 1'b1) && (a3 == 5'd0)}, 64'd0);
      chk("inv_one_grant", {63'd0, alu_ready & mem_ready}, 64'd0);
    end
  end

  initial begin
    rst_n = 1'b0;
    issue(1'b1, 5'd1, 5'd2, 5'd3);
    alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'd9;
    mem_valid = 1'b1; mem_rd = 5'd6; mem_data = 32'd8;

    // ---- reset state ----
    #12;
    chk("rst_we3", {63'd0, we3}, 64'd0);
    chk("rst_a3", {59'd0, a3}, 64'd0);
    chk("rst_wd3", {32'd0, wd3}, 64'd0);
    chk("rst_alu_ready", {63'd0, alu_ready}, 64'd0);
    chk("rst_mem_ready", {63'd0, mem_ready}, 64'd0);
    chk("rst_stall", {63'd0, iss_stall}, 64'd0);
    alu_valid = 1'b0; mem_valid = 1'b0; issue(1'b0, 5'd0, 5'd0, 5'd0);
    rst_n = 1'b1;
    tick;

    // ---- RAW hazard on x5 and its retire ----
    issue(1'b1, 5'd5, 5'd1, 5'd2);
    #1 chk("t1_issue5_stall", {63'd0, iss_stall}, 64'd0);
    tick;
    issue(1'b1, 5'd6, 5'd5, 5'd0);
    #1 chk("t1_rs1_busy_stall", {63'd0, iss_stall}, 64'd1);
    tick;
    issue(1'b0, 5'd0, 5'd0, 5'd0);
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'd42;
    #1 chk("t1_alu_ready", {63'd0, alu_ready}, 64'd1);
    chk("t1_mem_ready", {63'd0, mem_ready}, 64'd0);
    tick;
    alu_valid = 1'b0;
    chk("t1_we3", {63'd0, we3}, 64'd1);
    chk("t1_a3", {59'd0, a3}, 64'd5);
    chk("t1_wd3", {32'd0, wd3}, 64'd42);
    issue(1'b1, 5'd0, 5'd5, 5'd0);
    #1 chk("t1_stall_dropped", {63'd0, iss_stall}, 64'd0);
    tick;
    issue(1'b0, 5'd0, 5'd0, 5'd0);
    chk("t1_we3_pulse", {63'd0, we3}, 64'd0);
    chk("t1_a3_hold", {59'd0, a3}, 64'd5);
    chk("t1_wd3_hold", {32'd0, wd3}, 64'd42);

    // ---- round-robin: last grant was alu, so mem goes first ----
    alu_valid = 1'b1; alu_rd = 5'd10; alu_data = 32'd100;
    mem_valid = 1'b1; mem_rd = 5'd11; mem_data = 32'd200;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t2_mem_ready", {63'd0, mem_ready}, (i % 2 == 0) ? 64'd1 : 64'd0);
      chk("t2_alu_ready", {63'd0, alu_ready}, (i % 2 == 0) ? 64'd0 : 64'd1);
      tick;
      chk("t2_we3", {63'd0, we3}, 64'd1);
      chk("t2_a3", {59'd0, a3}, (i % 2 == 0) ? 64'd11 : 64'd10);
      chk("t2_wd3", {32'd0, wd3}, (i % 2 == 0) ? 64'd200 : 64'd100);
    end
    alu_valid = 1'b0; mem_valid = 1'b0;

    // ---- load result to x0 ----
    mem_valid = 1'b1; mem_rd = 5'd0; mem_data = 32'd122;
    #1 chk("t3_mem_ready", {63'd0, mem_ready}, 64'd1);
    tick;
    mem_valid = 1'b0;
    chk("t3_we3_x0", {63'd0, we3}, 64'd0);

    // ---- same-edge issue and retire on x7: set wins ----
    issue(1'b1, 5'd7, 5'd1, 5'd2);
    alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'd77;
    #1 chk("t4_issue_stall", {63'd0, iss_stall}, 64'd0);
    chk("t4_alu_ready", {63'd0, alu_ready}, 64'd1);
    tick;
    alu_valid = 1'b0;
    chk("t4_we3", {63'd0, we3}, 64'd1);
    chk("t4_a3", {59'd0, a3}, 64'd7);
    issue(1'b1, 5'd8, 5'd1, 5'd7);
    #1 chk("t4_rs2_busy_stall", {63'd0, iss_stall}, 64'd1);
    tick;
    issue(1'b0, 5'd0, 5'd0, 5'd0);

    // ---- reset mid-handshake with x3 and x9 busy ----
    issue(1'b1, 5'd3, 5'd0, 5'd0);
    #1 chk("t5_issue3", {63'd0, iss_stall}, 64'd0);
    tick;
    issue(1'b1, 5'd9, 5'd0, 5'd0);
    #1 chk("t5_issue9", {63'd0, iss_stall}, 64'd0);
    tick;
    issue(1'b1, 5'd0, 5'd9, 5'd3);
    #1 chk("t5_busy_before_rst", {63'd0, iss_stall}, 64'd1);
    issue(1'b0, 5'd0, 5'd0, 5'd0);
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'd55;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_we3", {63'd0, we3}, 64'd0);
    chk("t5_rst_a3", {59'd0, a3}, 64'd0);
    chk("t5_rst_alu_ready", {63'd0, alu_ready}, 64'd0);
    chk("t5_rst_busy", {32'd0, dut.u_sb.busy_q}, 64'd0);
    alu_valid = 1'b0;
    #1 rst_n = 1'b1;
    issue(1'b1, 5'd0, 5'd3, 5'd9);
    #1 chk("t5_no_stall", {63'd0, iss_stall}, 64'd0);
    tick;
    issue(1'b0, 5'd0, 5'd0, 5'd0);
    chk("t5_no_write", {63'd0, we3}, 64'd0);

    // ---- arbiter back to mem-first after reset ----
    alu_valid = 1'b1; alu_rd = 5'd12; alu_data = 32'd1;
    mem_valid = 1'b1; mem_rd = 5'd13; mem_data = 32'd2;
    #1 chk("t5_mem_first", {63'd0, mem_ready}, 64'd1);
    chk("t5_alu_wait", {63'd0, alu_ready}, 64'd0);
    tick;
    alu_valid = 1'b0; mem_valid = 1'b0;
    chk("t5_a3_mem", {59'd0, a3}, 64'd13);
    tick;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
